// File: rtl/twitchcore_mem_resp.sv
// rtl/twitchcore_mem_resp.sv - single-port data-memory responder with tohost halt register
module twitchcore_mem_resp #(
    parameter int                DEPTH_WORDS = 1024,
    parameter int                ADDR_W      = 32,
    parameter int                LATENCY     = 1,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_FFF0)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              halt,
    output logic [31:0]       tohost_value
);

    localparam int                IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] RAM_BYTES = ADDR_W'(DEPTH_WORDS * 4);
    localparam logic [3:0]        LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [31:0]       mem [DEPTH_WORDS];
    logic              accept;
    logic              in_range;
    logic              is_tohost;
    logic [IDX_W-1:0]  idx;

    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];
    assign in_range  = req_addr < RAM_BYTES;
    assign is_tohost = req_addr[ADDR_W-1:2] == TOHOST_ADDR[ADDR_W-1:2];

    // RAM has no reset so its contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
            halt         <= 1'b0;
            tohost_value <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'd0;
                        // Read data is captured now, so the response reflects RAM at acceptance.
                        if (in_range) begin
                            if (!req_we) begin
                                rsp_rdata <= mem[idx];
                            end
                        end else if (is_tohost) begin
                            if (req_we) begin
                                tohost_value <= req_wdata;
                                halt         <= 1'b1;
                            end else begin
                                rsp_rdata <= tohost_value;
                            end
                        end else begin
                            rsp_err <= 1'b1;
                        end
                        if (LATENCY > 1) begin
                            state <= S_WAIT;
                            cnt   <= LAT_M1;
                        end else begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        cnt       <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
